// File: rtl/hazard_ctrl_sb.sv
// Hazard unit for the 5-stage RV64 core: M/W forwarding, load-use stalls, redirect flushes and a
// multi-cycle op scoreboard. Define HAZ_PERF_CNT_EN to build the stall_cycles performance counter.
module hazard_ctrl_sb #(
  parameter int NREGS    = 32,
  parameter int LOAD_LAT = 1,
  parameter int MAX_MC   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] rs1_d,
  input  logic [$clog2(NREGS)-1:0] rs2_d,
  input  logic [$clog2(NREGS)-1:0] rd_d,
  input  logic                     mc_op_d,
  input  logic [$clog2(NREGS)-1:0] rs1_e,
  input  logic [$clog2(NREGS)-1:0] rs2_e,
  input  logic [$clog2(NREGS)-1:0] rd_e,
  input  logic [1:0]               result_src_e,
  input  logic                     mc_issue_e,
  input  logic [$clog2(NREGS)-1:0] rd_m,
  input  logic [$clog2(NREGS)-1:0] rd_w,
  input  logic                     reg_write_m,
  input  logic                     reg_write_w,
  input  logic [1:0]               pc_src_e,
  input  logic                     mc_done,
  input  logic [$clog2(NREGS)-1:0] mc_rd,
  output logic                     stall_f,
  output logic                     stall_d,
  output logic                     flush_d,
  output logic                     flush_e,
  output logic [1:0]               forward_ae,
  output logic [1:0]               forward_be,
  output logic                     mc_busy,
  output logic [31:0]              stall_cycles
);

  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(MAX_MC + 1);
  localparam int LW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pendNext;
  logic [CW-1:0]    mcCnt;
  logic [LW-1:0]    ldCnt;
  logic             redir;
  logic             luHz;
  logic             ldStall;
  logic             mcFull;
  logic             sbHz;
  logic             hazard;
  logic             unusedSrcBit;

  assign unusedSrcBit = result_src_e[1];

  // Register 0 never reads as pending, and indices beyond NREGS read as clear.
  function automatic logic pendAt(input logic [NREGS-1:0] vec, input logic [AW-1:0] idx);
    pendAt = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      if (idx == AW'(i)) pendAt = vec[i];
    end
  endfunction

  function automatic logic [1:0] fwdSel(input logic [AW-1:0] rs);
    fwdSel = 2'b00;
    if (rs != '0 && reg_write_m && rs == rd_m)      fwdSel = 2'b10;
    else if (rs != '0 && reg_write_w && rs == rd_w) fwdSel = 2'b01;
  endfunction

  function automatic logic [31:0] satInc32(input logic [31:0] v);
    satInc32 = (v == '1) ? v : v + 32'd1;
  endfunction

  always_comb begin
    redir   = pc_src_e != 2'b00;
    luHz    = result_src_e[0] && rd_e != '0 && (rs1_d == rd_e || rs2_d == rd_e);
    ldStall = luHz || ldCnt != '0;
    mcFull  = mcCnt == CW'(MAX_MC);
    sbHz    = pendAt(pend, rs1_d) | pendAt(pend, rs2_d) | pendAt(pend, rd_d) | (mc_op_d & mcFull);
    hazard  = ldStall | sbHz;
  end

  // Outputs are forced low for the whole time reset is held.
  assign stall_f    = ~rst & hazard & ~redir;
  assign stall_d    = ~rst & hazard & ~redir;
  assign flush_e    = ~rst & (hazard | redir);
  assign flush_d    = ~rst & redir;
  assign forward_ae = rst ? 2'b00 : fwdSel(rs1_e);
  assign forward_be = rst ? 2'b00 : fwdSel(rs2_e);
  assign mc_busy    = ~rst & (mcCnt != '0);

  // An issue and a completion on the same register leave it pending.
  always_comb begin
    pendNext = pend;
    if (mc_done) begin
      for (int i = 0; i < NREGS; i++) begin
        if (mc_rd == AW'(i)) pendNext[i] = 1'b0;
      end
    end
    if (mc_issue_e) begin
      for (int i = 1; i < NREGS; i++) begin
        if (rd_e == AW'(i)) pendNext[i] = 1'b1;
      end
    end
    pendNext[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= pendNext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcCnt <= '0;
    end else begin
      case ({mc_issue_e, mc_done})
        2'b10:   if (!mcFull)      mcCnt <= mcCnt + CW'(1);
        2'b01:   if (mcCnt != '0)  mcCnt <= mcCnt - CW'(1);
        default: mcCnt <= mcCnt;
      endcase
    end
  end

  // A redirect flushes the dependent decode instruction, so any remaining load bubbles are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ldCnt <= '0;
    end else if (redir) begin
      ldCnt <= '0;
    end else if (ldCnt != '0) begin
      ldCnt <= ldCnt - LW'(1);
    end else if (luHz) begin
      ldCnt <= LW'(LOAD_LAT - 1);
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stallCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt <= '0;
    end else if (stall_d) begin
      stallCnt <= satInc32(stallCnt);
    end
  end

  assign stall_cycles = stallCnt;
`else
  logic [31:0] unusedSat;
  assign unusedSat    = satInc32(32'd0);
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Bench for hazard_ctrl_sb: directed scenarios plus randomized traffic against a behavioural model.
module tb_hazard_ctrl_sb;

  localparam int NREGS    = 32;
  localparam int LOAD_LAT = 3;
  localparam int MAX_MC   = 2;
  localparam int AW       = $clog2(NREGS);

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, mc_rd;
  logic          mc_op_d, mc_issue_e, reg_write_m, reg_write_w, mc_done;
  logic [1:0]    result_src_e, pc_src_e;
  logic          stall_f, stall_d, flush_d, flush_e, mc_busy;
  logic [1:0]    forward_ae, forward_be;
  logic [31:0]   stall_cycles;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit     pendM[NREGS];
  int     inFlight;
  int     loadLeft;
  longint perf;

  // Outputs sampled in the last step
  logic       sStallF, sStallD, sFlushD, sFlushE, sBusy;
  logic [1:0] sFwdA, sFwdB;
  logic [31:0] sPerf;

  hazard_ctrl_sb #(.NREGS(NREGS), .LOAD_LAT(LOAD_LAT), .MAX_MC(MAX_MC)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .mc_op_d(mc_op_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .result_src_e(result_src_e),
    .mc_issue_e(mc_issue_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .pc_src_e(pc_src_e),
    .mc_done(mc_done), .mc_rd(mc_rd),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .forward_ae(forward_ae), .forward_be(forward_be), .mc_busy(mc_busy),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < NREGS; i++) pendM[i] = 0;
    inFlight = 0;
    loadLeft = 0;
    perf     = 0;
  endtask

  function automatic int fwdModel(input int rs);
    if (rs != 0 && reg_write_m && rs == int'(rd_m)) return 2;
    if (rs != 0 && reg_write_w && rs == int'(rd_w)) return 1;
    return 0;
  endfunction

  task automatic clearInputs();
    rs1_d = '0; rs2_d = '0; rd_d = '0; mc_op_d = 0;
    rs1_e = '0; rs2_e = '0; rd_e = '0; result_src_e = 2'b00; mc_issue_e = 0;
    rd_m = '0; rd_w = '0; reg_write_m = 0; reg_write_w = 0;
    pc_src_e = 2'b00; mc_done = 0; mc_rd = '0;
  endtask

  // One clock: compare at the falling edge, then advance the model to the next cycle.
  task automatic step();
    bit lu, sb, redirect, stallNow, loadStall;
    int expFa, expFb;
    @(negedge clk);
    sStallF = stall_f; sStallD = stall_d; sFlushD = flush_d; sFlushE = flush_e;
    sBusy = mc_busy; sFwdA = forward_ae; sFwdB = forward_be; sPerf = stall_cycles;
    if (rst) begin
      resetModel();
      checkVal("rst_stall_f", 32'(sStallF), 0);
      checkVal("rst_stall_d", 32'(sStallD), 0);
      checkVal("rst_flush_d", 32'(sFlushD), 0);
      checkVal("rst_flush_e", 32'(sFlushE), 0);
      checkVal("rst_fwd_a", 32'(sFwdA), 0);
      checkVal("rst_fwd_b", 32'(sFwdB), 0);
      checkVal("rst_busy", 32'(sBusy), 0);
      checkVal("rst_perf", sPerf, 0);
    end else begin
      redirect  = pc_src_e != 0;
      lu        = result_src_e[0] && rd_e != 0 && (rs1_d == rd_e || rs2_d == rd_e);
      loadStall = lu || loadLeft > 0;
      sb        = pendM[rs1_d] || pendM[rs2_d] || pendM[rd_d] || (mc_op_d && inFlight == MAX_MC);
      stallNow  = (loadStall || sb) && !redirect;
      expFa     = fwdModel(int'(rs1_e));
      expFb     = fwdModel(int'(rs2_e));
      checkVal("stall_f", 32'(sStallF), 32'(stallNow));
      checkVal("stall_d", 32'(sStallD), 32'(stallNow));
      checkVal("flush_d", 32'(sFlushD), 32'(redirect));
      checkVal("flush_e", 32'(sFlushE), 32'(loadStall || sb || redirect));
      checkVal("fwd_a", 32'(sFwdA), 32'(expFa));
      checkVal("fwd_b", 32'(sFwdB), 32'(expFb));
      checkVal("mc_busy", 32'(sBusy), 32'(inFlight != 0));
`ifdef HAZ_PERF_CNT_EN
      checkVal("perf", sPerf, 32'(perf));
`else
      checkVal("perf", sPerf, 0);
`endif
      if (redirect)          loadLeft = 0;
      else if (loadLeft > 0) loadLeft--;
      else if (lu)           loadLeft = LOAD_LAT - 1;
      if (mc_done) pendM[mc_rd] = 0;
      if (mc_issue_e && rd_e != 0) pendM[rd_e] = 1;
      if (mc_issue_e && !mc_done && inFlight < MAX_MC) inFlight++;
      if (mc_done && !mc_issue_e && inFlight > 0) inFlight--;
      if (stallNow && perf < 64'hFFFF_FFFF) perf++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clearInputs();
    resetModel();
    rst = 1;
    rs1_e = 5; rd_m = 5; reg_write_m = 1; pc_src_e = 2'b01;
    result_src_e = 2'b01; rd_e = 4; rs1_d = 4;
    step();
    step();
    rst = 0;
    clearInputs();

    // Forwarding priority
    rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1; rs1_e = 5; rs2_e = 5;
    step(); checkVal("fwd_m", 32'(sFwdA), 2);
    reg_write_m = 0;
    step(); checkVal("fwd_w", 32'(sFwdA), 1);
    rs1_e = 0;
    step(); checkVal("fwd_x0", 32'(sFwdA), 0);
    clearInputs();

    // Load-use: exactly LOAD_LAT stall cycles
    result_src_e = 2'b01; rd_e = 7; rs2_d = 7;
    step(); checkVal("lu_c0", 32'(sStallD), 1); checkVal("lu_c0_fe", 32'(sFlushE), 1);
    clearInputs();
    step(); checkVal("lu_c1", 32'(sStallF), 1);
    step(); checkVal("lu_c2", 32'(sStallD), 1);
    step(); checkVal("lu_c3", 32'(sStallD), 0);

    // Scoreboard RAW on a pending multi-cycle result
    mc_issue_e = 1; rd_e = 9;
    step(); checkVal("sb_issue", 32'(sStallD), 0);
    clearInputs(); rs1_d = 9;
    step(); checkVal("sb_wait", 32'(sStallD), 1); checkVal("sb_busy", 32'(sBusy), 1);
    step();
    mc_done = 1; mc_rd = 9;
    step(); checkVal("sb_done_cyc", 32'(sStallD), 1);
    mc_done = 0;
    step(); checkVal("sb_release", 32'(sStallD), 0); checkVal("sb_idle", 32'(sBusy), 0);
    clearInputs();

    // Outstanding-op limit
    mc_issue_e = 1; rd_e = 10; step();
    rd_e = 11; step();
    clearInputs(); mc_op_d = 1; rs1_d = 1; rs2_d = 2; rd_d = 3;
    step(); checkVal("mc_full", 32'(sStallD), 1);
    mc_done = 1; mc_rd = 10;
    step(); checkVal("mc_full_done", 32'(sStallD), 1);
    mc_done = 0;
    step(); checkVal("mc_room", 32'(sStallD), 0);
    clearInputs(); mc_done = 1; mc_rd = 11; step();
    clearInputs();

    // Redirect overrides and cancels a load-use stall
    result_src_e = 2'b01; rd_e = 7; rs1_d = 7; pc_src_e = 2'b01;
    step();
    checkVal("redir_fd", 32'(sFlushD), 1); checkVal("redir_fe", 32'(sFlushE), 1);
    checkVal("redir_sf", 32'(sStallF), 0);
    clearInputs();
    step(); checkVal("redir_after", 32'(sStallD), 0);

    // Asynchronous reset in the middle of a scoreboard stall
    mc_issue_e = 1; rd_e = 9; step();
    clearInputs(); rs1_d = 9;
    step(); checkVal("pre_rst", 32'(sStallD), 1);
    rst = 1;
    #1;
    checkVal("arst_stall", 32'(stall_d), 0);
    checkVal("arst_flush_e", 32'(flush_e), 0);
    checkVal("arst_busy", 32'(mc_busy), 0);
    step();
    rst = 0;
    step();
    checkVal("post_rst_stall", 32'(sStallD), 0);
    checkVal("post_rst_busy", 32'(sBusy), 0);
    checkVal("post_rst_perf", sPerf, 0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rs1_d = AW'($urandom_range(0, 7)); rs2_d = AW'($urandom_range(0, 7));
      rd_d  = AW'($urandom_range(0, 7)); mc_op_d = ($urandom_range(0, 3) == 0);
      rs1_e = AW'($urandom_range(0, 7)); rs2_e = AW'($urandom_range(0, 7));
      rd_e  = AW'($urandom_range(0, 7)); result_src_e = 2'($urandom_range(0, 3));
      mc_issue_e = ($urandom_range(0, 4) == 0);
      rd_m = AW'($urandom_range(0, 7)); rd_w = AW'($urandom_range(0, 7));
      reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
      pc_src_e = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      mc_done = ($urandom_range(0, 3) == 0); mc_rd = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 150) == 0) rst = 1;
      step();
      rst = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
